reg_file_param: RTL and testbench



---
 rtl/reg_file_pkg.sv | 16 +
 rtl/rf_clear_seq.sv | 58 +++++
 rtl/reg_file_param.sv | 73 +++++++
 tb/tb_reg_file_param.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the parametrised register file and its clear sequencer.
package reg_file_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_N_RD    = 2;
  localparam int DEF_BYPASS  = 1;
  localparam int DEF_ZERO_R0 = 0;

  typedef enum logic {IDLE, SWEEP} rf_state_t;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear-sweep sequencer: walks every entry once, zeroing one per cycle, and flags writes
// that arrive while a sweep is requested or running.
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic              WRITE,
  output logic              BUSY,
  output logic              DROPPED,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  rf_state_t         state;
  logic [ADDR_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      BUSY    <= 1'b0;
      DROPPED <= 1'b0;
    end else begin
      DROPPED <= 1'b0;
      case (state)
        IDLE: begin
          if (CLEAR) begin
            state   <= SWEEP;
            cnt     <= '0;
            BUSY    <= 1'b1;
            DROPPED <= WRITE;
          end
        end
        SWEEP: begin
          // CLEAR is deliberately ignored here; a sweep is never restarted.
          DROPPED <= WRITE;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clr_en   = (state == SWEEP);
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Multi-port register file: N_RD combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero entry 0, sequenced clear.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_RD    = DEF_N_RD,
  parameter int BYPASS  = DEF_BYPASS,
  parameter int ZERO_R0 = DEF_ZERO_R0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WRITE,
  input  logic [ADDR_W-1:0]        INADDRESS,
  input  logic [DATA_W-1:0]        IN,
  input  logic [N_RD*ADDR_W-1:0]   OUTADDRESS,
  output logic [N_RD*DATA_W-1:0]   OUT,
  input  logic                     CLEAR,
  output logic                     BUSY,
  output logic                     DROPPED
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              r0_discard;
  logic              user_we;

  rf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .CLK      (CLK),
    .RESET    (RESET),
    .CLEAR    (CLEAR),
    .WRITE    (WRITE),
    .BUSY     (BUSY),
    .DROPPED  (DROPPED),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign r0_discard = (ZERO_R0 != 0) && (INADDRESS == '0);
  assign user_we    = WRITE && !BUSY && !CLEAR && !r0_discard;

  // NOTE: the array is reset explicitly because OUT must read zero as soon as RESET asserts.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (user_we) begin
      mem[INADDRESS] <= IN;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = OUTADDRESS[k*ADDR_W +: ADDR_W];

    // NOTE: rd gets its default first so no path through this block can infer a latch.
    always_comb begin
      rd = mem[ra];
      if ((BYPASS != 0) && user_we && (ra == INADDRESS)) rd = IN;
      if ((ZERO_R0 != 0) && (ra == '0)) rd = '0;
    end

    assign OUT[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: bypass, non-bypass and zero-r0 variants share one stimulus.
module tb_reg_file_param;

  logic        CLK;
  logic        RESET;
  logic        WRITE;
  logic [2:0]  INADDRESS;
  logic [7:0]  IN;
  logic [5:0]  OUTADDRESS;
  logic        CLEAR;

  logic [15:0] out_a, out_nb, out_z;
  logic        busy_a, busy_nb, busy_z;
  logic        drop_a, drop_nb, drop_z;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file_param dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUTADDRESS(OUTADDRESS), .OUT(out_a), .CLEAR(CLEAR), .BUSY(busy_a), .DROPPED(drop_a)
  );

  reg_file_param #(.BYPASS(0)) dut_nb (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUTADDRESS(OUTADDRESS), .OUT(out_nb), .CLEAR(CLEAR), .BUSY(busy_nb), .DROPPED(drop_nb)
  );

  reg_file_param #(.ZERO_R0(1)) dut_z (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUTADDRESS(OUTADDRESS), .OUT(out_z), .CLEAR(CLEAR), .BUSY(busy_z), .DROPPED(drop_z)
  );

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    WRITE = 1'b1; INADDRESS = a; IN = d;
    cyc();
    WRITE = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] a;
    for (int i = 0; i < 8; i++) preload(3'(i), 8'hA5);
    OUTADDRESS = {3'd3, 3'd6};
    #1;
    n_cmp++;
    if (out_a !== 16'hA5A5) begin
      n_bad++; $display("FAIL reset_preload: got %h want %h", out_a, 16'hA5A5);
    end
    #3 RESET = 1'b1;
    #1;
    n_cmp++;
    if (busy_a !== 1'b0 || drop_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got busy=%b dropped=%b want 0 0", busy_a, drop_a);
    end
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      OUTADDRESS = {a, a};
      #1;
      n_cmp++;
      if (out_a !== 16'h0000) begin
        n_bad++; $display("FAIL reset_entry%0d: got %h want 0000", i, out_a);
      end
    end
    RESET = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    OUTADDRESS = {3'd5, 3'd5};
    WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h3C;
    #1;
    n_cmp++;
    if (out_a !== 16'h3C3C) begin
      n_bad++; $display("FAIL bypass_same_cycle: got %h want 3c3c", out_a);
    end
    n_cmp++;
    if (out_nb !== 16'h0000) begin
      n_bad++; $display("FAIL nobypass_same_cycle: got %h want 0000", out_nb);
    end
    cyc();
    WRITE = 1'b0;
    #1;
    n_cmp++;
    if (out_nb !== 16'h3C3C) begin
      n_bad++; $display("FAIL nobypass_after_edge: got %h want 3c3c", out_nb);
    end
    n_cmp++;
    if (out_a !== 16'h3C3C) begin
      n_bad++; $display("FAIL bypass_after_edge: got %h want 3c3c", out_a);
    end
    // Independent ports: only the port addressing the write target sees the bypass.
    OUTADDRESS = {3'd4, 3'd6};
    WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h5A;
    #1;
    n_cmp++;
    if (out_a !== 16'h005A) begin
      n_bad++; $display("FAIL bypass_port_independence: got %h want 005a", out_a);
    end
    cyc();
    WRITE = 1'b0;
  endtask

  task automatic test_sweep();
    logic [2:0] a;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) preload(3'(i), 8'((i + 1) * 8'h11));
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL sweep_idle_busy: got %b want 0", busy_a);
    end
    CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0;
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (busy_a !== 1'b1) begin
        n_bad++; $display("FAIL sweep_busy_c%0d: got %b want 1", c, busy_a);
      end
      for (int k = 0; k < 8; k++) begin
        a = 3'(k);
        OUTADDRESS = {3'd0, a};
        exp = (k < c) ? 8'h00 : 8'((k + 1) * 8'h11);
        #1;
        n_cmp++;
        if (out_a[7:0] !== exp) begin
          n_bad++; $display("FAIL sweep_c%0d_e%0d: got %h want %h", c, k, out_a[7:0], exp);
        end
      end
      cyc();
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL sweep_busy_end: got %b want 0", busy_a);
    end
    OUTADDRESS = {3'd7, 3'd0};
    #1;
    n_cmp++;
    if (out_a !== 16'h0000) begin
      n_bad++; $display("FAIL sweep_end_entries: got %h want 0000", out_a);
    end
  endtask

  task automatic test_collision();
    preload(3'd0, 8'h10);
    preload(3'd1, 8'h20);
    preload(3'd2, 8'h55);
    OUTADDRESS = {3'd0, 3'd2};
    CLEAR = 1'b1; WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h77;
    #1;
    n_cmp++;
    if (out_a[7:0] !== 8'h55) begin
      n_bad++; $display("FAIL coll_no_bypass_on_clear: got %h want 55", out_a[7:0]);
    end
    cyc();
    CLEAR = 1'b0; WRITE = 1'b0;
    n_cmp++;
    if (drop_a !== 1'b1 || busy_a !== 1'b1) begin
      n_bad++; $display("FAIL coll_drop1: got dropped=%b busy=%b want 1 1", drop_a, busy_a);
    end
    cyc();
    OUTADDRESS = {3'd1, 3'd0};
    #1;
    n_cmp++;
    if (drop_a !== 1'b0) begin
      n_bad++; $display("FAIL coll_drop1_width: got %b want 0", drop_a);
    end
    n_cmp++;
    if (out_a !== 16'h2000) begin
      n_bad++; $display("FAIL coll_sweep_restart_at_0: got %h want 2000", out_a);
    end
    cyc();
    cyc();
    // Sweep cycle 4: write plus a stray CLEAR, both must be ignored.
    OUTADDRESS = {3'd0, 3'd2};
    WRITE = 1'b1; CLEAR = 1'b1; INADDRESS = 3'd2; IN = 8'h77;
    #1;
    n_cmp++;
    if (out_a[7:0] !== 8'h00) begin
      n_bad++; $display("FAIL coll_no_bypass_busy: got %h want 00", out_a[7:0]);
    end
    cyc();
    WRITE = 1'b0; CLEAR = 1'b0;
    n_cmp++;
    if (drop_a !== 1'b1) begin
      n_bad++; $display("FAIL coll_drop2: got %b want 1", drop_a);
    end
    cyc();
    n_cmp++;
    if (drop_a !== 1'b0) begin
      n_bad++; $display("FAIL coll_drop2_width: got %b want 0", drop_a);
    end
    cyc();
    cyc();
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++; $display("FAIL coll_busy_e7: got %b want 1", busy_a);
    end
    cyc();
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL coll_clear_ignored: got busy=%b want 0", busy_a);
    end
    n_cmp++;
    if (out_a[7:0] !== 8'h00 || out_nb[7:0] !== 8'h00) begin
      n_bad++; $display("FAIL coll_addr2_final: got %h/%h want 00/00", out_a[7:0], out_nb[7:0]);
    end
  endtask

  task automatic test_zero_r0();
    OUTADDRESS = {3'd1, 3'd0};
    WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hFF;
    #1;
    n_cmp++;
    if (out_z[7:0] !== 8'h00) begin
      n_bad++; $display("FAIL zr0_same_cycle: got %h want 00", out_z[7:0]);
    end
    cyc();
    WRITE = 1'b0;
    #1;
    n_cmp++;
    if (out_z[7:0] !== 8'h00 || drop_z !== 1'b0) begin
      n_bad++; $display("FAIL zr0_after_edge: got %h dropped=%b want 00 0", out_z[7:0], drop_z);
    end
    n_cmp++;
    if (out_a[7:0] !== 8'hFF) begin
      n_bad++; $display("FAIL r0_normal_write: got %h want ff", out_a[7:0]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [2:0] a;
    preload(3'd6, 8'h66);
    CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0;
    cyc();
    cyc();
    cyc();
    #4 RESET = 1'b1;
    #1;
    n_cmp++;
    if (busy_a !== 1'b0 || drop_a !== 1'b0) begin
      n_bad++; $display("FAIL midreset_flags: got busy=%b dropped=%b want 0 0", busy_a, drop_a);
    end
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      OUTADDRESS = {a, a};
      #1;
      n_cmp++;
      if (out_nb !== 16'h0000) begin
        n_bad++; $display("FAIL midreset_entry%0d: got %h want 0000", i, out_nb);
      end
    end
    OUTADDRESS = {3'd7, 3'd7};
    WRITE = 1'b1; INADDRESS = 3'd7; IN = 8'h42;
    #1 RESET = 1'b0;
    cyc();
    WRITE = 1'b0;
    #1;
    n_cmp++;
    if (out_nb !== 16'h4242 || out_a !== 16'h4242) begin
      n_bad++; $display("FAIL midreset_first_write: got %h/%h want 4242/4242", out_nb, out_a);
    end
    n_cmp++;
    if (busy_a !== 1'b0 || drop_a !== 1'b0) begin
      n_bad++; $display("FAIL midreset_write_flags: got busy=%b dropped=%b want 0 0", busy_a, drop_a);
    end
  endtask

  initial begin
    RESET = 1'b1; WRITE = 1'b0; CLEAR = 1'b0;
    INADDRESS = '0; IN = '0; OUTADDRESS = '0;
    #25 RESET = 1'b0;
    cyc();
    test_reset();
    test_write_read();
    test_sweep();
    test_collision();
    test_zero_r0();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
